// File: rtl/rpsc_lamp_annunciator_if.sv
// Lamp annunciator bus: latched fault flags, operator controls and panel drive.
// The master side is card 8 plus the operator panel; the slave side is the annunciator.
interface rpsc_lamp_annunciator_if #(
    parameter int unsigned N_CH = 7
);
    localparam int unsigned IDX_W = (N_CH > 1) ? $clog2(N_CH) : 1;

    logic [N_CH-1:0]  i_fault;
    logic             i_ack;
    logic             i_lamptest;
    logic [N_CH-1:0]  o_lamp;
    logic             o_horn;
    logic             o_first_valid;
    logic [IDX_W-1:0] o_first_idx;
    logic             o_any_fault;

    modport master (
        output i_fault, i_ack, i_lamptest,
        input  o_lamp, o_horn, o_first_valid, o_first_idx, o_any_fault
    );

    modport slave (
        input  i_fault, i_ack, i_lamptest,
        output o_lamp, o_horn, o_first_valid, o_first_idx, o_any_fault
    );
endinterface

// File: rtl/rpsc_lamp_annunciator.sv
// Front-panel lamp/horn annunciator for the RPSC card-8 fault flags.
// Captures the first-out fault, blinks its lamp until acknowledged, and supports a
// stretched lamp test. All outputs are registered from the next-state values.
module rpsc_lamp_annunciator #(
    parameter int unsigned N_CH         = 7,
    parameter int unsigned BLINK_HALF   = 25_000_000,
    parameter int unsigned LAMPTEST_MIN = 50_000_000
) (
    input logic                    clk,
    input logic                    reset,
    rpsc_lamp_annunciator_if.slave bus
);
    localparam int unsigned IDX_W = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int unsigned CNT_W = $clog2(BLINK_HALF);
    localparam int unsigned STR_W = $clog2(LAMPTEST_MIN + 1);

    typedef enum logic [1:0] {StNormal, StAlarm, StAcked} state_e;

    state_e           state_q, state_d;
    logic [N_CH-1:0]  fault_q;
    logic [N_CH-1:0]  new_fault;
    logic             any_new;
    logic [IDX_W-1:0] new_idx;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [CNT_W-1:0] blink_cnt_q;
    logic             blink_wrap;
    logic             blink_phase_q, blink_phase_d;
    logic [STR_W-1:0] stretch_q;
    logic             test_on;
    logic [N_CH-1:0]  lamp_d;

    assign new_fault     = bus.i_fault & ~fault_q;
    assign any_new       = |new_fault;
    assign blink_wrap    = (blink_cnt_q == CNT_W'(BLINK_HALF - 1));
    assign blink_phase_d = blink_wrap ? ~blink_phase_q : blink_phase_q;
    assign test_on       = bus.i_lamptest || (stretch_q != '0);

    // Lowest-numbered newly risen channel wins the first-out slot.
    always_comb begin
        new_idx = '0;
        for (int k = N_CH - 1; k >= 0; k--) begin
            if (new_fault[k]) new_idx = IDX_W'(k);
        end
    end

    // Next state of the alarm FSM; a new edge always beats an acknowledge.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        unique case (state_q)
            StNormal: begin
                if (any_new) begin
                    state_d = StAlarm;
                    idx_d   = new_idx;
                end
            end
            StAlarm: begin
                if (!any_new && bus.i_ack) begin
                    if (bus.i_fault == '0) begin
                        state_d = StNormal;
                        idx_d   = '0;
                    end else begin
                        state_d = StAcked;
                    end
                end
            end
            StAcked: begin
                if (any_new) begin
                    state_d = StAlarm;
                end else if (bus.i_fault == '0) begin
                    state_d = StNormal;
                    idx_d   = '0;
                end
            end
            default: begin
                state_d = StNormal;
                idx_d   = '0;
            end
        endcase
    end

    // Lamp pattern: faults steady, first-out blinks while alarming, lamp test forces all on.
    always_comb begin
        lamp_d = bus.i_fault;
        if (state_d == StAlarm) lamp_d[idx_d] = blink_phase_d;
        if (test_on) lamp_d = '1;
    end

    // Edge-detect history, free-running blink timebase and lamp test stretch.
    always_ff @(posedge clk) begin
        if (reset) begin
            fault_q       <= '0;
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b1;
            stretch_q     <= '0;
        end else begin
            fault_q       <= bus.i_fault;
            blink_cnt_q   <= blink_wrap ? '0 : blink_cnt_q + 1'b1;
            blink_phase_q <= blink_phase_d;
            if (bus.i_lamptest) begin
                stretch_q <= STR_W'(LAMPTEST_MIN);
            end else if (stretch_q != '0) begin
                stretch_q <= stretch_q - 1'b1;
            end
        end
    end

    // FSM state, first-out index and all registered panel outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q           <= StNormal;
            idx_q             <= '0;
            bus.o_lamp        <= '0;
            bus.o_horn        <= 1'b0;
            bus.o_first_valid <= 1'b0;
            bus.o_first_idx   <= '0;
            bus.o_any_fault   <= 1'b0;
        end else begin
            state_q           <= state_d;
            idx_q             <= idx_d;
            bus.o_lamp        <= lamp_d;
            bus.o_horn        <= (state_d == StAlarm);
            bus.o_first_valid <= (state_d != StNormal);
            bus.o_first_idx   <= idx_d;
            bus.o_any_fault   <= |bus.i_fault;
        end
    end
endmodule
